// File: rtl/cpu_pkg.sv
// Shared definitions for the operand-2 path: shift types, sequencer states, field positions.
package cpu_pkg;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RM_RD = 3'd1,
    RS_RD = 3'd2,
    SHF   = 3'd3,
    CAP   = 3'd4,
    OUT   = 3'd5
  } state_t;

  // Bit positions inside the data-processing instruction word.
  localparam int IMM_BIT       = 25;
  localparam int REG_SHIFT_BIT = 4;
  localparam int IMM8_LSB      = 0;
  localparam int ROT_LSB       = 8;
  localparam int RM_LSB        = 0;
  localparam int RS_LSB        = 8;
  localparam int TYPE_LSB      = 5;
  localparam int AMT_LSB       = 7;

  // Immediate rotate field counts in steps of two bit positions.
  function automatic logic [4:0] rot_amount(input logic [3:0] rot);
    return {rot, 1'b0};
  endfunction

endpackage

// File: rtl/reg_shift_fixup.sv
// Resolves register-specified shift amounts the 5-bit shifter cannot express (0, >=32, ROR multiples of 32).
// Purely combinational; bypass_o=1 means operand_o/carry_o are final and the shifter is skipped.
module reg_shift_fixup
  import cpu_pkg::*;
(
  input  logic [31:0] rm_i,
  input  logic [7:0]  n_i,
  input  logic [1:0]  type_i,
  input  logic        c_i,
  output logic        bypass_o,
  output logic [31:0] operand_o,
  output logic        carry_o
);

  always_comb begin
    bypass_o  = 1'b0;
    operand_o = rm_i;
    carry_o   = c_i;
    if (n_i == 8'd0) begin
      bypass_o = 1'b1;
    end else begin
      case (type_i)
        LSL: if (n_i >= 8'd32) begin
          bypass_o  = 1'b1;
          operand_o = '0;
          carry_o   = (n_i == 8'd32) ? rm_i[0] : 1'b0;
        end
        LSR: if (n_i >= 8'd32) begin
          bypass_o  = 1'b1;
          operand_o = '0;
          carry_o   = (n_i == 8'd32) ? rm_i[31] : 1'b0;
        end
        ASR: if (n_i >= 8'd32) begin
          bypass_o  = 1'b1;
          operand_o = {32{rm_i[31]}};
          carry_o   = rm_i[31];
        end
        default: if (n_i[4:0] == 5'd0) begin
          bypass_o = 1'b1;
          carry_o  = rm_i[31];
        end
      endcase
    end
  end

endmodule

// File: rtl/shifter_operand_ctrl.sv
// Operand-2 sequencer: decodes the shifter field, reads Rm/Rs, drives the registered barrel shifter.
// Register-specified shifts are built only when SHIFT_REG_EN is defined; otherwise they return op_illegal.
module shifter_operand_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        c_flag,
  output logic [3:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [31:0] sh_in,
  output logic [1:0]  sh_type,
  output logic [4:0]  sh_imm,
  output logic        sh_cin,
  input  logic [31:0] sh_result,
  input  logic        sh_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] operand,
  output logic        carry_out,
  output logic        op_illegal
);

  state_t      state_q, state_d;
  logic [11:0] ctl_q, ctl_d;
  logic        c_q, c_d;
  logic [3:0]  raddr_q, raddr_d;
  logic [31:0] sh_in_q, sh_in_d;
  logic [1:0]  sh_type_q, sh_type_d;
  logic [4:0]  sh_imm_q, sh_imm_d;
  logic        sh_cin_q, sh_cin_d;
  logic [31:0] op_q, op_d;
  logic        cy_q, cy_d;
  logic        ill_q, ill_d;

  logic [1:0]  ctl_type;
  logic [4:0]  ctl_amt;
  logic        unused_ok;

  assign ctl_type  = ctl_q[TYPE_LSB +: 2];
  assign ctl_amt   = ctl_q[AMT_LSB +: 5];
  assign unused_ok = ^{instr[31:26], instr[24:12], ctl_q[3:0]};

`ifdef SHIFT_REG_EN
  logic [31:0] rm_q, rm_d;
  logic        fx_bypass;
  logic [31:0] fx_operand;
  logic        fx_carry;

  reg_shift_fixup u_fixup (
    .rm_i      (rm_q),
    .n_i       (rf_rdata[7:0]),
    .type_i    (ctl_type),
    .c_i       (c_q),
    .bypass_o  (fx_bypass),
    .operand_o (fx_operand),
    .carry_o   (fx_carry)
  );
`endif

  always_comb begin
    state_d   = state_q;
    ctl_d     = ctl_q;
    c_d       = c_q;
    raddr_d   = raddr_q;
    sh_in_d   = sh_in_q;
    sh_type_d = sh_type_q;
    sh_imm_d  = sh_imm_q;
    sh_cin_d  = sh_cin_q;
    op_d      = op_q;
    cy_d      = cy_q;
    ill_d     = ill_q;
`ifdef SHIFT_REG_EN
    rm_d      = rm_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        ctl_d = instr[11:0];
        c_d   = c_flag;
        ill_d = 1'b0;
        if (instr[IMM_BIT]) begin
          if (instr[ROT_LSB +: 4] == 4'd0) begin
            op_d    = {24'd0, instr[IMM8_LSB +: 8]};
            cy_d    = c_flag;
            state_d = OUT;
          end else begin
            sh_in_d   = {24'd0, instr[IMM8_LSB +: 8]};
            sh_type_d = ROR;
            sh_imm_d  = rot_amount(instr[ROT_LSB +: 4]);
            sh_cin_d  = c_flag;
            state_d   = SHF;
          end
        end else begin
          raddr_d = instr[RM_LSB +: 4];
          state_d = RM_RD;
        end
      end
      RM_RD: begin
        if (!ctl_q[REG_SHIFT_BIT]) begin
          if (ctl_type == LSL && ctl_amt == 5'd0) begin
            op_d    = rf_rdata;
            cy_d    = c_q;
            state_d = OUT;
          end else begin
            sh_in_d   = rf_rdata;
            sh_type_d = ctl_type;
            sh_imm_d  = ctl_amt;
            sh_cin_d  = c_q;
            state_d   = SHF;
          end
        end else begin
`ifdef SHIFT_REG_EN
          rm_d    = rf_rdata;
          raddr_d = ctl_q[RS_LSB +: 4];
          state_d = RS_RD;
`else
          op_d    = '0;
          cy_d    = c_q;
          ill_d   = 1'b1;
          state_d = OUT;
`endif
        end
      end
`ifdef SHIFT_REG_EN
      RS_RD: begin
        if (fx_bypass) begin
          op_d    = fx_operand;
          cy_d    = fx_carry;
          state_d = OUT;
        end else begin
          sh_in_d   = rm_q;
          sh_type_d = ctl_type;
          sh_imm_d  = rf_rdata[4:0];
          sh_cin_d  = c_q;
          state_d   = SHF;
        end
      end
`endif
      SHF: state_d = CAP;
      CAP: begin
        op_d    = sh_result;
        cy_d    = sh_cout;
        state_d = OUT;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ctl_q     <= '0;
      c_q       <= 1'b0;
      raddr_q   <= '0;
      sh_in_q   <= '0;
      sh_type_q <= '0;
      sh_imm_q  <= '0;
      sh_cin_q  <= 1'b0;
      op_q      <= '0;
      cy_q      <= 1'b0;
      ill_q     <= 1'b0;
`ifdef SHIFT_REG_EN
      rm_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      c_q       <= c_d;
      raddr_q   <= raddr_d;
      sh_in_q   <= sh_in_d;
      sh_type_q <= sh_type_d;
      sh_imm_q  <= sh_imm_d;
      sh_cin_q  <= sh_cin_d;
      op_q      <= op_d;
      cy_q      <= cy_d;
      ill_q     <= ill_d;
`ifdef SHIFT_REG_EN
      rm_q      <= rm_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == OUT);
  assign rf_raddr   = raddr_q;
  assign sh_in      = sh_in_q;
  assign sh_type    = sh_type_q;
  assign sh_imm     = sh_imm_q;
  assign sh_cin     = sh_cin_q;
  assign operand    = op_q;
  assign carry_out  = cy_q;
  assign op_illegal = ill_q;

endmodule

// File: tb/tb_shifter_operand_ctrl.sv
// Directed bench for shifter_operand_ctrl with a register-file model and a registered barrel-shifter model.
module tb_shifter_operand_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        c_flag = 1'b0;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] sh_in;
  logic [1:0]  sh_type;
  logic [4:0]  sh_imm;
  logic        sh_cin;
  logic [31:0] sh_result = '0;
  logic        sh_cout = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] operand;
  logic        carry_out;
  logic        op_illegal;

  logic [31:0] rf [16];
  int errs = 0;
  int checks = 0;

  shifter_operand_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .c_flag(c_flag), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .sh_in(sh_in), .sh_type(sh_type), .sh_imm(sh_imm), .sh_cin(sh_cin),
    .sh_result(sh_result), .sh_cout(sh_cout), .out_valid(out_valid),
    .out_ready(out_ready), .operand(operand), .carry_out(carry_out),
    .op_illegal(op_illegal)
  );

  always #5 clk = ~clk;

  assign rf_rdata = rf[rf_raddr];

  // Barrel shifter: amount 0 means LSR/ASR #32 and RRX for ROR.
  function automatic logic [32:0] shf(input logic [31:0] x, input logic [1:0] t,
                                      input logic [4:0] amt, input logic cin);
    int a;
    logic [31:0] r;
    logic c;
    a = int'(amt);
    case (t)
      2'b00: begin
        if (a == 0) begin r = x; c = cin; end
        else begin r = x << a; c = x[32 - a]; end
      end
      2'b01: begin
        if (a == 0) begin r = '0; c = x[31]; end
        else begin r = x >> a; c = x[a - 1]; end
      end
      2'b10: begin
        if (a == 0) begin r = {32{x[31]}}; c = x[31]; end
        else begin r = 32'($signed(x) >>> a); c = x[a - 1]; end
      end
      default: begin
        if (a == 0) begin r = {cin, x[31:1]}; c = x[0]; end
        else begin r = (x >> a) | (x << (32 - a)); c = r[31]; end
      end
    endcase
    return {c, r};
  endfunction

  always @(posedge clk) {sh_cout, sh_result} <= shf(sh_in, sh_type, sh_imm, sh_cin);

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        c;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [31:0] op;
    logic        cy;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] imm_i(input logic [3:0] rot, input logic [7:0] imm8);
    return (32'd1 << 25) | {20'd0, rot, imm8};
  endfunction

  // Rm is always r2, Rs is always r3.
  function automatic logic [31:0] rsh_i(input logic [1:0] t, input logic [4:0] amt);
    return {20'd0, amt, t, 1'b0, 4'd2};
  endfunction

  function automatic logic [31:0] rrs_i(input logic [1:0] t);
    return {20'd0, 4'd3, 1'b0, t, 1'b1, 4'd2};
  endfunction

  task automatic add(input string nm, input logic [31:0] ins, input logic c,
                     input logic [31:0] rm, input logic [31:0] rs,
                     input logic [31:0] op, input logic cy, input int lat);
    vec_t v;
    v.name = nm; v.instr = ins; v.c = c; v.rm = rm; v.rs = rs;
    v.op = op; v.cy = cy; v.ill = 1'b0; v.lat = lat;
`ifndef SHIFT_REG_EN
    if (!ins[25] && ins[4]) begin
      v.op = '0; v.cy = c; v.ill = 1'b1; v.lat = 2;
    end
`endif
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic accept(input logic [31:0] ins, input logic c, input string nm);
    @(negedge clk);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; instr = ins; c_flag = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    c_flag = ~c;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    rf[2] = v.rm;
    rf[3] = v.rs;
    accept(v.instr, v.c, v.name);
    wait_out(lat);
    chk({v.name, ".lat"}, 32'(lat), 32'(v.lat));
    chk({v.name, ".operand"}, operand, v.op);
    chk({v.name, ".carry"}, 32'(carry_out), 32'(v.cy));
    chk({v.name, ".illegal"}, 32'(op_illegal), 32'(v.ill));
    release_out(v.name);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 16; i++) rf[i] = 32'hDEAD_0000 | 32'(i);

    add("imm_rot0",   imm_i(4'd0, 8'hFF), 1'b1, 32'h0, 32'h0, 32'h0000_00FF, 1'b1, 1);
    add("imm_rot4",   imm_i(4'd4, 8'h3F), 1'b0, 32'h0, 32'h0, 32'h3F00_0000, 1'b0, 3);
    add("imm_rot1",   imm_i(4'd1, 8'h03), 1'b0, 32'h0, 32'h0, 32'hC000_0000, 1'b1, 3);
    add("lsl0",       rsh_i(2'b00, 5'd0), 1'b0, 32'h8000_0001, 32'h0, 32'h8000_0001, 1'b0, 2);
    add("lsl4",       rsh_i(2'b00, 5'd4), 1'b0, 32'h1000_000F, 32'h0, 32'h0000_00F0, 1'b1, 4);
    add("lsr32",      rsh_i(2'b01, 5'd0), 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 4);
    add("asr1",       rsh_i(2'b10, 5'd1), 1'b0, 32'h8000_0003, 32'h0, 32'hC000_0001, 1'b1, 4);
    add("rrx",        rsh_i(2'b11, 5'd0), 1'b1, 32'h0000_0003, 32'h0, 32'h8000_0001, 1'b1, 4);
    add("rr_lsr32",   rrs_i(2'b01), 1'b0, 32'h8000_0000, 32'd32,  32'h0, 1'b1, 3);
    add("rr_lsr33",   rrs_i(2'b01), 1'b0, 32'h8000_0000, 32'd33,  32'h0, 1'b0, 3);
    add("rr_lsr256",  rrs_i(2'b01), 1'b1, 32'h8000_0000, 32'h100, 32'h8000_0000, 1'b1, 3);
    add("rr_ror4",    rrs_i(2'b11), 1'b0, 32'h0000_000F, 32'd4,   32'hF000_0000, 1'b1, 5);
    add("rr_ror32",   rrs_i(2'b11), 1'b0, 32'h8000_0000, 32'h20,  32'h8000_0000, 1'b1, 3);
    add("rr_lsl32",   rrs_i(2'b00), 1'b0, 32'h0000_0001, 32'd32,  32'h0, 1'b1, 3);
    add("rr_lsl40",   rrs_i(2'b00), 1'b1, 32'hFFFF_FFFF, 32'd40,  32'h0, 1'b0, 3);
    add("rr_asr40",   rrs_i(2'b10), 1'b0, 32'h8000_0000, 32'd40,  32'hFFFF_FFFF, 1'b1, 3);
    add("rr_lsl1",    rrs_i(2'b00), 1'b0, 32'h8000_0001, 32'd1,   32'h0000_0002, 1'b1, 5);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.operand", operand, 32'd0);
    chk("rst.flags", {29'd0, carry_out, op_illegal, sh_cin}, 32'd0);
    chk("rst.sh", {21'd0, sh_type, sh_imm, rf_raddr}, 32'd0);
    chk("rst.sh_in", sh_in, 32'd0);

    run_vec(vecs[0]);
    chk("imm_rot0.sh_untouched", {sh_in[24:0], sh_type, sh_imm}, 32'd0);

    for (int i = 1; i < vecs.size(); i++) run_vec(vecs[i]);

    // Stall in OUT for 10 cycles while a second instruction is offered.
    accept(imm_i(4'd4, 8'h3F), 1'b0, "stall");
    wait_out(lat);
    chk("stall.lat", 32'(lat), 32'd3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = (k > 2 && k < 8);
      instr = imm_i(4'd0, 8'h55);
      @(posedge clk);
      #1;
      chk($sformatf("stall.c%0d.ctl", k), {28'd0, out_valid, in_ready, carry_out, op_illegal}, 32'h8);
      chk($sformatf("stall.c%0d.operand", k), operand, 32'h3F00_0000);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out("stall");

    // Reset while the shifter is busy drops the instruction.
    accept(imm_i(4'd4, 8'h3F), 1'b0, "rst_shf");
    rst = 1'b1;
    #1;
    chk("rst_shf.out_valid", 32'(out_valid), 32'd0);
    chk("rst_shf.operand", operand, 32'd0);
    chk("rst_shf.sh_in", sh_in, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_shf.dropped", {30'd0, out_valid, in_ready}, 32'd1);
    run_vec(vecs[11]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/shifter_operand_ctrl.md
# shifter_operand_ctrl

Sequencer that decodes the data-processing operand-2 field, fetches Rm/Rs from the register file, and drives the registered barrel shifter. It sits between the instruction decoder and the ALU. It resolves the cases the 5-bit shifter cannot express: immediate rotates, LSL #0 carry preservation, and register-specified amounts of 0 or 32 and above. It returns one operand and one carry per accepted instruction over a valid/ready handshake.

## Interface
- No parameters; all widths are fixed by the ARM data-processing format.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoder presents an instruction.
- in_ready  out  1  block can accept; equals (state == IDLE).
- instr  in  32  instruction; bits 25, 11:0 used.
- c_flag  in  1  CPSR C, sampled at accept.
- rf_raddr  out  4  register-file read address; read is combinational, data valid the same cycle.
- rf_rdata  in  32  register-file read data.
- sh_in / sh_type / sh_imm / sh_cin  out  32/2/5/1  barrel-shifter operands.
- sh_result / sh_cout  in  32/1  shifter outputs, valid one clk after the operands are held.
- out_valid  out  1  operand available.
- out_ready  in  1  ALU consumes.
- operand  out  32  shifter operand.
- carry_out  out  1  shifter carry.
- op_illegal  out  1  qualifies out_valid; unsupported encoding.

## Operation
- States: IDLE, RM_RD, RS_RD, SHF, CAP, OUT.
- IDLE:
  - On in_valid, latch instr and c_flag (C).
  - bit25=1 (immediate): imm8=instr[7:0], rot=instr[11:8].
    - rot==0: operand=imm8, carry=C, go to OUT.
    - Otherwise: sh_in=imm8 zero-extended, sh_type=ROR, sh_imm=2*rot, go to SHF.
  - bit25=0: go to RM_RD.
- RM_RD: rf_raddr=instr[3:0]; latch Rm.
  - bit4=0 (immediate shift): type=instr[6:5], amt=instr[11:7].
    - LSL with amt==0: operand=Rm, carry=C, go to OUT.
    - Otherwise: drive the shifter with the raw type and amt, go to SHF. The shifter handles the LSR/ASR #0 (=32) and RRX encodings.
  - bit4=1: go to RS_RD.
- RS_RD: rf_raddr=instr[11:8]; n=Rs[7:0].
  - n==0: operand=Rm, carry=C, go to OUT.
  - LSL n==32: operand 0, carry Rm[0], go to OUT.
  - LSL n>32: operand 0, carry 0, go to OUT.
  - LSR n==32: operand 0, carry Rm[31], go to OUT.
  - LSR n>32: operand 0, carry 0, go to OUT.
  - ASR n>=32: operand and carry both Rm[31] replicated, go to OUT.
  - ROR n[4:0]==0 (n!=0): operand=Rm, carry=Rm[31], go to OUT.
  - Any other n: shifter with sh_imm=n[4:0], go to SHF.
- SHF: hold sh_* stable; sh_cin=C; go to CAP.
- CAP: hold sh_*; operand=sh_result, carry_out=sh_cout; go to OUT.
- OUT: out_valid=1, outputs held stable; on out_ready go to IDLE.
- Reset values: state IDLE; out_valid, operand, carry_out, op_illegal, rf_raddr and all sh_* are 0. in_ready is 1 once rst deasserts.

## Timing
- Latency is measured from the accept edge to out_valid:
  - imm rot0: 1.
  - imm rot≠0: 3.
  - reg imm-shift bypass: 2.
  - reg imm-shift via shifter: 4.
  - reg-reg bypass: 3.
  - reg-reg via shifter: 5.
- in_valid is ignored outside IDLE. The minimum turnaround is one IDLE cycle after the OUT handshake.
- out_ready held low stalls indefinitely in OUT with all outputs frozen.
- rst asserted in any state: outputs go to reset values immediately, the in-flight instruction is dropped, the block returns to IDLE.
- sh_* change only on leaving IDLE, RM_RD or RS_RD.

## Configuration
- SHIFT_REG_EN defined: register-specified shifts (bit25=0, bit4=1) are supported as above.
- SHIFT_REG_EN undefined: the RS_RD state is removed. bit4=1 goes from RM_RD directly to OUT with op_illegal=1, operand=0, carry=C.

## Structure
- Shared package cpu_pkg:
  - shift-type constants LSL/LSR/ASR/ROR (00/01/10/11);
  - state encoding;
  - operand-2 field bit positions.
- Sub-module reg_shift_fixup: combinational. Inputs Rm, n[7:0], type, C. Outputs bypass, operand, carry. Instantiated only under SHIFT_REG_EN.

## Test plan
- Immediate rot=0, imm8=0xFF, C=1 -> after 1 cycle operand 0x000000FF, carry 1; sh_* untouched.
- Immediate rot=4, imm8=0x3F, C=0 -> after 3 cycles operand 0x3F000000, carry 0.
- Reg LSL #0, Rm=0x80000001, C=0 -> after 2 cycles operand 0x80000001, carry 0.
- Reg-reg LSR, Rm=0x80000000:
  - Rs=32 -> operand 0, carry 1.
  - Rs=33 -> operand 0, carry 0.
  - Rs=0x100 -> operand Rm, carry C.
- Reg-reg ROR, Rm=0x0000000F, Rs=4 -> after 5 cycles operand 0xF0000000, carry 1. Rs=0x20 with Rm=0x80000000 -> operand Rm, carry 1.
- out_ready low 10 cycles:
  - outputs stable and in_ready 0 throughout;
  - rst pulsed in SHF -> out_valid 0 at once, IDLE, next instruction correct.
